// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared types and constants for the RV32M multiply/divide unit
package mdu_pkg;

  localparam int XLEN        = 32;
  localparam int MDU_LATENCY = 32;

  typedef enum logic [2:0] {
    MUL_F3    = 3'b000,
    MULH_F3   = 3'b001,
    MULHSU_F3 = 3'b010,
    MULHU_F3  = 3'b011,
    DIV_F3    = 3'b100,
    DIVU_F3   = 3'b101,
    REM_F3    = 3'b110,
    REMU_F3   = 3'b111
  } funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic logic [XLEN-1:0] negate_if(input logic neg, input logic [XLEN-1:0] v);
    return neg ? (~v + 1'b1) : v;
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative RV32M multiply/divide, fixed 32-cycle latency
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH = XLEN
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Start,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] RuRs1,
  input  logic [WIDTH-1:0] RuRs2,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  localparam int W = WIDTH;
  localparam logic [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};

  state_e           state_q, state_d;
  logic [5:0]       cnt_q, cnt_d;
  funct3_e          f3_q, f3_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [2*W-1:0]   acc_q, acc_d;
  logic [W:0]       rem_q, rem_d;
  logic             neg_res_q, neg_res_d, neg_rem_q, neg_rem_d;
  logic             div0_q, div0_d, ovf_q, ovf_d;
  logic [W-1:0]     result_q, result_d;

  logic             accept, is_div_in, a_signed_in, b_signed_in, a_neg_in, b_neg_in;
  logic [W-1:0]     a_mag_in, b_mag_in;
  logic             is_div_q, last_iter;
  logic [W:0]       mul_sum, rem_shift, rem_nxt;
  logic             div_ge;
  logic [2*W-1:0]   mul_acc_nxt, div_acc_nxt, prod;
  logic [W-1:0]     mul_res, quo_res, rem_res, final_res;

  assign accept      = Start && (state_q != CALC);
  assign is_div_in   = Funct3[2];
  assign a_signed_in = (Funct3 == MULH_F3) || (Funct3 == MULHSU_F3) ||
                       (Funct3 == DIV_F3)  || (Funct3 == REM_F3);
  assign b_signed_in = (Funct3 == MULH_F3) || (Funct3 == DIV_F3) || (Funct3 == REM_F3);
  assign a_neg_in    = a_signed_in && RuRs1[W-1];
  assign b_neg_in    = b_signed_in && RuRs2[W-1];
  assign a_mag_in    = negate_if(a_neg_in, RuRs1);
  assign b_mag_in    = negate_if(b_neg_in, RuRs2);

  // Multiply: upper half accumulates, multiplier bits drain out of the lower half.
  assign mul_sum     = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : {(W+1){1'b0}});
  assign mul_acc_nxt = {mul_sum, acc_q[W-1:1]};

  // Divide: dividend shifts out of acc low half while quotient bits shift in.
  assign rem_shift   = {rem_q[W-1:0], acc_q[W-1]};
  assign div_ge      = rem_shift >= {1'b0, b_q};
  assign rem_nxt     = div_ge ? (rem_shift - {1'b0, b_q}) : rem_shift;
  assign div_acc_nxt = {acc_q[2*W-1:W], acc_q[W-2:0], div_ge};

  assign is_div_q    = f3_q[2];
  assign last_iter   = (state_q == CALC) && (cnt_q == 6'(MDU_LATENCY - 1));

  assign prod        = neg_res_q ? (~mul_acc_nxt + 1'b1) : mul_acc_nxt;
  assign mul_res     = (f3_q == MUL_F3) ? prod[W-1:0] : prod[2*W-1:W];
  assign quo_res     = div0_q ? {W{1'b1}} :
                       ovf_q  ? SMIN      : negate_if(neg_res_q, div_acc_nxt[W-1:0]);
  assign rem_res     = div0_q ? negate_if(neg_rem_q, a_q) :
                       ovf_q  ? {W{1'b0}} : negate_if(neg_rem_q, rem_nxt[W-1:0]);
  assign final_res   = !is_div_q ? mul_res : (f3_q[1] ? rem_res : quo_res);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    f3_d      = f3_q;
    a_d       = a_q;
    b_d       = b_q;
    acc_d     = acc_q;
    rem_d     = rem_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    div0_d    = div0_q;
    ovf_d     = ovf_q;
    result_d  = result_q;

    case (state_q)
      CALC: begin
        cnt_d = cnt_q + 6'd1;
        acc_d = is_div_q ? div_acc_nxt : mul_acc_nxt;
        if (is_div_q) rem_d = rem_nxt;
        if (last_iter) begin
          state_d  = DONE;
          result_d = final_res;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (accept) begin
      state_d   = CALC;
      cnt_d     = 6'd0;
      f3_d      = funct3_e'(Funct3);
      a_d       = a_mag_in;
      b_d       = b_mag_in;
      acc_d     = {{W{1'b0}}, (is_div_in ? a_mag_in : b_mag_in)};
      rem_d     = {(W+1){1'b0}};
      neg_res_d = a_neg_in ^ b_neg_in;
      neg_rem_d = a_neg_in;
      div0_d    = is_div_in && (RuRs2 == {W{1'b0}});
      ovf_d     = ((Funct3 == DIV_F3) || (Funct3 == REM_F3)) &&
                  (RuRs1 == SMIN) && (RuRs2 == {W{1'b1}});
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= 6'd0;
      f3_q      <= MUL_F3;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      rem_q     <= '0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      a_q       <= a_d;
      b_q       <= b_d;
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      div0_q    <= div0_d;
      ovf_q     <= ovf_d;
      result_q  <= result_d;
    end
  end

  assign Busy   = (state_q == CALC);
  assign Done   = (state_q == DONE);
  assign Result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// tb/tb_mul_div_unit.sv - directed self-checking bench for mul_div_unit
module tb_mul_div_unit;
  import mdu_pkg::*;

  logic        Clk = 1'b0;
  logic        Rst_n;
  logic        Start;
  logic [2:0]  Funct3;
  logic [31:0] RuRs1, RuRs2;
  logic        Busy, Done;
  logic [31:0] Result;

  int total = 0;
  int bad   = 0;

  always #5 Clk = ~Clk;

  mul_div_unit #(.WIDTH(32)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Start(Start), .Funct3(Funct3),
    .RuRs1(RuRs1), .RuRs2(RuRs2), .Busy(Busy), .Done(Done), .Result(Result)
  );

  // Drive one Start pulse, then scramble the inputs to prove they were latched.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    Funct3 = f3; RuRs1 = a; RuRs2 = b; Start = 1'b1;
    @(posedge Clk); #1;
    Start = 1'b0; Funct3 = 3'b011; RuRs1 = 32'hA5A5_5A5A; RuRs2 = 32'h1234_5678;
  endtask

  // Cycles until Done (or -1 after a bounded wait); busy_ok clears if Busy dropped early.
  task automatic wait_done(output int lat, output logic busy_ok);
    lat = -1; busy_ok = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      @(posedge Clk); #1;
      if (Done) begin lat = i; break; end
      if (!Busy) busy_ok = 1'b0;
    end
  endtask

  task automatic test_reset;
    Rst_n = 1'b0; Start = 1'b0; Funct3 = 3'b000; RuRs1 = '0; RuRs2 = '0;
    #1;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", Done); end
    total++; if (Result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", Result); end
    @(posedge Clk); @(posedge Clk); #1;
    Rst_n = 1'b1;
    @(posedge Clk); #1;
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%b exp=0", Busy); end
  endtask

  task automatic test_mul;
    int lat; logic bok;
    issue(MUL_F3, 32'd7, 32'hFFFF_FFFD);
    total++; if (Busy !== 1'b1) begin bad++; $display("FAIL mul_busy_after_accept got=%b exp=1", Busy); end
    wait_done(lat, bok);
    total++; if (lat !== 32) begin bad++; $display("FAIL mul_latency got=%0d exp=32", lat); end
    total++; if (bok !== 1'b1) begin bad++; $display("FAIL mul_busy_hold got=%b exp=1", bok); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL mul_busy_at_done got=%b exp=0", Busy); end
    total++; if (Result !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul_result got=%h exp=ffffffeb", Result); end
    @(posedge Clk); #1;
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL mul_done_pulse got=%b exp=0", Done); end
    total++; if (Result !== 32'hFFFF_FFEB) begin bad++; $display("FAIL mul_result_hold got=%h exp=ffffffeb", Result); end
  endtask

  task automatic test_ops(input string name, input int n,
                          input logic [2:0] f3s[8], input logic [31:0] as[8],
                          input logic [31:0] bs[8], input logic [31:0] exps[8]);
    int lat; logic bok;
    for (int i = 0; i < n; i++) begin
      issue(f3s[i], as[i], bs[i]);
      wait_done(lat, bok);
      total++;
      if (lat !== 32 || bok !== 1'b1) begin
        bad++; $display("FAIL %s_latency[%0d] got=%0d busy_ok=%b exp=32", name, i, lat, bok);
      end
      total++;
      if (Result !== exps[i]) begin
        bad++; $display("FAIL %s_result[%0d] got=%h exp=%h", name, i, Result, exps[i]);
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_high_mul;
    logic [2:0]  f3s[8];
    logic [31:0] as[8], bs[8], exps[8];
    f3s[0] = MULH_F3;   as[0] = 32'h8000_0000; bs[0] = 32'h8000_0000; exps[0] = 32'h4000_0000;
    f3s[1] = MULHU_F3;  as[1] = 32'hFFFF_FFFF; bs[1] = 32'hFFFF_FFFF; exps[1] = 32'hFFFF_FFFE;
    f3s[2] = MULHSU_F3; as[2] = 32'hFFFF_FFFF; bs[2] = 32'hFFFF_FFFF; exps[2] = 32'hFFFF_FFFF;
    for (int i = 3; i < 8; i++) begin f3s[i] = '0; as[i] = '0; bs[i] = '0; exps[i] = '0; end
    test_ops("mulhi", 3, f3s, as, bs, exps);
  endtask

  task automatic test_div;
    logic [2:0]  f3s[8];
    logic [31:0] as[8], bs[8], exps[8];
    f3s[0] = DIV_F3;  as[0] = 32'hFFFF_FFF9; bs[0] = 32'd2; exps[0] = 32'hFFFF_FFFD;
    f3s[1] = REM_F3;  as[1] = 32'hFFFF_FFF9; bs[1] = 32'd2; exps[1] = 32'hFFFF_FFFF;
    f3s[2] = DIVU_F3; as[2] = 32'd100;       bs[2] = 32'd7; exps[2] = 32'd14;
    f3s[3] = REMU_F3; as[3] = 32'd100;       bs[3] = 32'd7; exps[3] = 32'd2;
    for (int i = 4; i < 8; i++) begin f3s[i] = '0; as[i] = '0; bs[i] = '0; exps[i] = '0; end
    test_ops("div", 4, f3s, as, bs, exps);
  endtask

  task automatic test_corner;
    logic [2:0]  f3s[8];
    logic [31:0] as[8], bs[8], exps[8];
    f3s[0] = DIV_F3;  as[0] = 32'd5;         bs[0] = 32'd0;         exps[0] = 32'hFFFF_FFFF;
    f3s[1] = REM_F3;  as[1] = 32'd5;         bs[1] = 32'd0;         exps[1] = 32'd5;
    f3s[2] = DIV_F3;  as[2] = 32'h8000_0000; bs[2] = 32'hFFFF_FFFF; exps[2] = 32'h8000_0000;
    f3s[3] = REM_F3;  as[3] = 32'h8000_0000; bs[3] = 32'hFFFF_FFFF; exps[3] = 32'h0;
    f3s[4] = DIVU_F3; as[4] = 32'd9;         bs[4] = 32'd0;         exps[4] = 32'hFFFF_FFFF;
    f3s[5] = REM_F3;  as[5] = 32'hFFFF_FFF6; bs[5] = 32'd0;         exps[5] = 32'hFFFF_FFF6;
    for (int i = 6; i < 8; i++) begin f3s[i] = '0; as[i] = '0; bs[i] = '0; exps[i] = '0; end
    test_ops("corner", 6, f3s, as, bs, exps);
  endtask

  task automatic test_back_to_back;
    int lat; logic bok;
    issue(DIVU_F3, 32'd100, 32'd7);
    for (int i = 1; i <= 9; i++) begin @(posedge Clk); #1; end
    issue(MUL_F3, 32'd1, 32'd1);
    wait_done(lat, bok);
    total++; if (lat !== 22) begin bad++; $display("FAIL ignored_start_latency got=%0d exp=22", lat); end
    total++; if (Result !== 32'd14) begin bad++; $display("FAIL ignored_start_result got=%h exp=0000000e", Result); end
    issue(MUL_F3, 32'd3, 32'd4);
    total++; if (Done !== 1'b0 || Busy !== 1'b1) begin
      bad++; $display("FAIL b2b_accept got=done%b/busy%b exp=done0/busy1", Done, Busy);
    end
    total++; if (Result !== 32'd14) begin bad++; $display("FAIL b2b_old_result got=%h exp=0000000e", Result); end
    wait_done(lat, bok);
    total++; if (lat + 1 !== 33) begin bad++; $display("FAIL b2b_done_gap got=%0d exp=33", lat + 1); end
    total++; if (Result !== 32'd12) begin bad++; $display("FAIL b2b_result got=%h exp=0000000c", Result); end
    @(posedge Clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat; logic bok; logic seen;
    issue(DIV_F3, 32'd1000, 32'd3);
    for (int i = 1; i <= 15; i++) begin @(posedge Clk); #1; end
    Rst_n = 1'b0;
    #1;
    total++; if (Busy !== 1'b0 || Done !== 1'b0) begin
      bad++; $display("FAIL midreset_ctrl got=busy%b/done%b exp=busy0/done0", Busy, Done);
    end
    total++; if (Result !== 32'h0) begin bad++; $display("FAIL midreset_result got=%h exp=0", Result); end
    @(posedge Clk); #1;
    Rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin @(posedge Clk); #1; if (Done) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midreset_no_done got=%b exp=0", seen); end
    issue(MUL_F3, 32'd3, 32'd4);
    wait_done(lat, bok);
    total++; if (lat !== 32) begin bad++; $display("FAIL post_reset_latency got=%0d exp=32", lat); end
    total++; if (Result !== 32'd12) begin bad++; $display("FAIL post_reset_result got=%h exp=0000000c", Result); end
  endtask

  initial begin
    test_reset;
    test_mul;
    test_high_mul;
    test_div;
    test_corner;
    test_back_to_back;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit sitting directly downstream of the register unit: it consumes the two register-read operands (RuRs1/RuRs2) for M-extension instructions and returns a 32-bit result that the writeback mux routes to RuDataWr. Each operation takes a fixed multi-cycle latency. Control logic holds the PC and the register-write enable while Busy is high, and writes Result on the Done cycle.

## Interface
- WIDTH, 32, operand/result width; only 32 is supported (iteration count = WIDTH).
- Clk  input  1  system clock, rising-edge active.
- Rst_n  input  1  asynchronous, active-low reset.
- Start  input  1  request a new operation; sampled on the rising edge.
- Funct3  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- RuRs1  input  WIDTH  operand A (multiplicand/dividend).
- RuRs2  input  WIDTH  operand B (multiplier/divisor).
- Busy  output  1  high while an operation is iterating.
- Done  output  1  one-cycle pulse; Result is valid during this cycle.
- Result  output  WIDTH  operation result; held until the next accepted Start.

## Operation
- FSM states: IDLE, CALC, DONE.
  - IDLE: if Start, go to CALC.
  - CALC: when the 32nd iteration completes, go to DONE.
  - DONE: go to IDLE, or to CALC if Start is high.
- Start is accepted only in IDLE or DONE. Start in CALC is ignored, with no queuing.
- On accept:
  - Latch Funct3 and both operands. Later input changes have no effect.
  - Convert signed operands to magnitudes:
    - MULH, DIV, REM: both operands signed.
    - MULHSU: A signed, B unsigned.
    - All others: unsigned.
  - Record the result sign:
    - Product and quotient sign = sign(A) XOR sign(B), using only the signed operands.
    - Remainder sign = sign(A).
  - Clear the iteration counter (6 bits).
- Multiply: shift-add over a 64-bit accumulator, one multiplier bit per cycle.
  - Negate the 64-bit product if the product sign is negative.
  - MUL returns bits [31:0]; MULH, MULHSU and MULHU return bits [63:32].
- Divide: restoring division, one quotient bit per cycle, with a 33-bit partial remainder.
  - Negate the quotient and remainder magnitudes per their recorded signs.
  - DIV/DIVU return the quotient; REM/REMU return the remainder.
- Special cases. These are detected at accept and substituted on entry to DONE; latency is unchanged.
  - Divisor 0: quotient = 0xFFFFFFFF for DIV and DIVU; remainder = A.
  - Signed overflow (A = 0x80000000, B = 0xFFFFFFFF, DIV/REM): quotient = 0x80000000, remainder = 0.
- Result register updates only on entry to DONE.

## Timing
- Reset (Rst_n low, asynchronous): state = IDLE, Busy = 0, Done = 0, Result = 0, counter = 0, and all internal accumulators cleared.
- Reset mid-CALC aborts the operation. No Done is produced. The first edge after release with Start high begins a fresh operation.
- Accept at edge k: Busy = 1 from after edge k through edge k+32.
- State = DONE after edge k+32: Done = 1 and Busy = 0 for that one cycle. Latency from the accepting edge to a visible Done is 32 cycles for every Funct3.
- Back-to-back: Start high in the DONE cycle is accepted at edge k+33. Done drops and Busy rises after that edge, and the old Result stays visible until the next Done.
- Done is never high two consecutive cycles.
- Outputs are registered. There is no combinational path from inputs to Busy, Done or Result.

## Structure
- Shared package mdu_pkg:
  - XLEN = 32.
  - funct3 enum: MUL_F3 … REMU_F3.
  - State enum: IDLE, CALC, DONE.
  - Constant MDU_LATENCY = 32, for use by control and the bench.
- Single module. Multiply and divide share the counter, the operand registers and the sign-fix logic, so no sub-module is warranted.

## Test plan
- MUL 7 × 0xFFFFFFFD → Result 0xFFFFFFEB. Done exactly 32 cycles after the Start edge, Busy high the whole time.
- High-half multiplies:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Divide/remainder:
  - DIV 0xFFFFFFF9 / 2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF.
  - DIVU 100 / 7 → 14; REMU → 2.
- Corner cases:
  - DIV 5 / 0 → 0xFFFFFFFF; REM 5 / 0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM → 0.
  - All still 32-cycle latency.
- Start pulsed at cycle 10 of an operation, with operands changed to 1 / 1: ignored, and the original result still appears. Back-to-back Start in the DONE cycle yields a second Done 33 cycles after the first.
- Rst_n asserted at cycle 15 of a DIV: Busy, Done and Result go to 0 immediately and no Done follows. After release, MUL 3 × 4 → 12.
